// File: rtl/id_queue_pkg.sv
// Shared types for the id_queue decode stage: decode_result layout, unit and
// load/store enums, and a popcount helper for lane-valid vectors.
package id_queue_pkg;

    typedef enum logic [1:0] {
        UNIT_NONE   = 2'd0,
        UNIT_ALU    = 2'd1,
        UNIT_BRANCH = 2'd2,
        UNIT_LDST   = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        LS_NONE  = 2'd0,
        LS_LOAD  = 2'd1,
        LS_STORE = 2'd2
    } ldst_mode_e;

    typedef struct packed {
        logic       is_valid;
        logic [10:0] op;
        logic [4:0]  qj;
        logic [4:0]  qk;
        logic [4:0]  dest;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        unit_e       unit;
        ldst_mode_e  rwmm;
        logic        a_rdy;
        logic [31:0] pc;
    } decode_result;

    // Callers zero-extend their N-bit vector to 32 bits.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/id_queue_if.sv
// Fetch/dispatch-facing bundle of id_queue; the queue takes the slave side.
interface id_queue_if
    import id_queue_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(N + 1);

    logic               flush;
    logic [N-1:0]       in_valid;
    logic [31:0]        instr [N];
    logic [31:0]        pc    [N];
    logic               in_ready;
    decode_result       out   [N];
    logic [OW-1:0]      out_count;
    logic [OW-1:0]      deq_num;
    logic [CW-1:0]      occupancy;

    modport master (
        output flush, in_valid, instr, pc, deq_num,
        input  in_ready, out, out_count, occupancy
    );

    modport slave (
        input  flush, in_valid, instr, pc, deq_num,
        output in_ready, out, out_count, occupancy
    );

endinterface

// File: rtl/decoder.sv
// Combinational RV32I-subset decoder producing one decode_result per lane.
module decoder
    import id_queue_pkg::*;
(
    input  logic [31:0]  instr,
    input  logic [31:0]  pc,
    output decode_result res
);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign rd    = instr[11:7];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};

    // Operand values (vj/vk) are filled in later from the register file.
    always_comb begin
        res          = '0;
        res.is_valid = 1'b1;
        res.pc       = pc;
        res.op       = {instr[30], instr[14:12], instr[6:0]};
        res.unit     = UNIT_NONE;
        res.rwmm     = LS_NONE;
        case (instr[6:0])
            7'b0110011: begin
                res.unit = UNIT_ALU;  res.qj = rs1; res.qk = rs2; res.dest = rd;
                res.a_rdy = 1'b1;
            end
            7'b0010011: begin
                res.unit = UNIT_ALU;  res.qj = rs1; res.dest = rd;
                res.a = imm_i; res.a_rdy = 1'b1;
            end
            7'b0110111: begin
                res.unit = UNIT_ALU;  res.dest = rd; res.a = imm_u; res.a_rdy = 1'b1;
            end
            7'b0010111: begin
                res.unit = UNIT_ALU;  res.dest = rd; res.a = pc + imm_u; res.a_rdy = 1'b1;
            end
            7'b0000011: begin
                res.unit = UNIT_LDST; res.rwmm = LS_LOAD; res.qj = rs1; res.dest = rd;
                res.a = imm_i;
            end
            7'b0100011: begin
                res.unit = UNIT_LDST; res.rwmm = LS_STORE; res.qj = rs1; res.qk = rs2;
                res.a = imm_s;
            end
            7'b1100011: begin
                res.unit = UNIT_BRANCH; res.qj = rs1; res.qk = rs2;
                res.a = pc + imm_b; res.a_rdy = 1'b1;
            end
            7'b1101111: begin
                res.unit = UNIT_BRANCH; res.dest = rd; res.a = pc + imm_j; res.a_rdy = 1'b1;
            end
            7'b1100111: begin
                res.unit = UNIT_BRANCH; res.qj = rs1; res.dest = rd; res.a = imm_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_queue_ram.sv
// DEPTH x decode_result storage, N write ports and N combinational read ports.
module id_queue_ram
    import id_queue_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic [N-1:0]  wr_en,
    input  logic [AW-1:0] wr_idx  [N],
    input  decode_result  wr_data [N],
    input  logic [AW-1:0] rd_idx  [N],
    output decode_result  rd_data [N]
);
    decode_result mem [DEPTH];

    // Write indices within one cycle are distinct by construction upstream.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (wr_en[k]) mem[wr_idx[k]] <= wr_data[k];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_data[i] = mem[rd_idx[i]];
        end
    end

endmodule

// File: rtl/id_queue.sv
// N-lane decode stage feeding a compacting circular decoded-instruction queue.
// Optional ID_QUEUE_PERF_EN adds stall_cycles / full_cycles counters.
module id_queue
    import id_queue_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 8
)(
    input  logic        clk,
    input  logic        rst_n,
    id_queue_if.slave   bus
`ifdef ID_QUEUE_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] full_cycles
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(N + 1);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          in_ready;
    logic [OW-1:0] out_count;
    logic [OW-1:0] eff_deq;
    logic          enq_fire;
    logic [CW-1:0] enq_cnt;

    decode_result  dec     [N];
    decode_result  rd_data [N];
    logic [N-1:0]  wr_en;
    logic [AW-1:0] wr_idx  [N];
    logic [AW-1:0] rd_idx  [N];

    for (genvar k = 0; k < N; k++) begin : g_dec
        decoder u_dec (
            .instr (bus.instr[k]),
            .pc    (bus.pc[k]),
            .res   (dec[k])
        );
    end

    id_queue_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (dec),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // in_ready looks only at registered count so deq_num never reaches it.
    assign in_ready  = (CW'(DEPTH) - count) >= CW'(N);
    assign out_count = (count >= CW'(N)) ? OW'(N) : OW'(count);
    assign eff_deq   = (bus.deq_num > out_count) ? out_count : bus.deq_num;
    assign enq_fire  = in_ready & (|bus.in_valid) & ~bus.flush;
    assign enq_cnt   = enq_fire ? CW'(popcount(32'(bus.in_valid))) : '0;

    // Compaction: each valid lane lands after the valid lanes below it.
    always_comb begin
        logic [CW-1:0] run;
        run = '0;
        for (int k = 0; k < N; k++) begin
            wr_en[k]  = enq_fire & bus.in_valid[k];
            wr_idx[k] = tail + AW'(run);
            if (bus.in_valid[k]) run = run + CW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rd_idx[i]           = head + AW'(i);
            bus.out[i]          = rd_data[i];
            bus.out[i].is_valid = rd_data[i].is_valid & (OW'(i) < out_count);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_count = out_count;
    assign bus.occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(eff_deq);
            tail  <= tail + AW'(enq_cnt);
            count <= count + enq_cnt - CW'(eff_deq);
        end
    end

`ifdef ID_QUEUE_PERF_EN
    // Perf counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            full_cycles  <= '0;
        end else begin
            if ((|bus.in_valid) & ~in_ready & ~bus.flush) stall_cycles <= stall_cycles + 32'd1;
            if (count == CW'(DEPTH))                      full_cycles  <= full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_queue.sv
// Directed + random bench for id_queue against a queue-of-PCs reference model.
module tb_id_queue;
    import id_queue_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 8;
    localparam int OW    = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    id_queue_if #(.N(N), .DEPTH(DEPTH)) bus ();

`ifdef ID_QUEUE_PERF_EN
    logic [31:0] stall_cycles, full_cycles;
`endif

    id_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ID_QUEUE_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .full_cycles  (full_cycles)
`endif
    );

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned mq [$];
    int unsigned m_stall  = 0;
    int unsigned m_full   = 0;
    logic [31:0] next_pc  = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [OW-1:0] dq, input logic fl);
        bus.in_valid = v;
        for (int k = 0; k < N; k++) begin
            bus.pc[k]    = next_pc;
            bus.instr[k] = $urandom;
            next_pc      = next_pc + 32'd4;
        end
        bus.deq_num = dq;
        bus.flush   = fl;
    endtask

    // Compare DUT state with the model, apply this cycle's inputs to the model, advance a clock.
    task automatic step();
        int sz, oc, eff;
        bit rdy;
        sz  = mq.size();
        oc  = (sz < N) ? sz : N;
        rdy = (DEPTH - sz) >= N;
        check("occupancy", 32'(bus.occupancy), 32'(sz));
        check("out_count", 32'(bus.out_count), 32'(oc));
        check("in_ready",  32'(bus.in_ready),  32'(rdy));
        for (int i = 0; i < N; i++) begin
            check("out_valid", 32'(bus.out[i].is_valid), 32'(i < oc));
            if (i < oc) check("out_pc", bus.out[i].pc, mq[i]);
        end
`ifdef ID_QUEUE_PERF_EN
        check("stall_cycles", stall_cycles, m_stall);
        check("full_cycles",  full_cycles,  m_full);
`endif
        if ((|bus.in_valid) && !rdy && !bus.flush) m_stall++;
        if (sz == DEPTH) m_full++;
        if (bus.flush) begin
            mq.delete();
        end else begin
            eff = (int'(bus.deq_num) < oc) ? int'(bus.deq_num) : oc;
            repeat (eff) void'(mq.pop_front());
            if (rdy)
                for (int k = 0; k < N; k++)
                    if (bus.in_valid[k]) mq.push_back(bus.pc[k]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_out_count", 32'(bus.out_count), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out0_valid", 32'(bus.out[0].is_valid), 32'd0);
        rst_n = 1'b1;
        repeat (5) step();

        // Full group, then read it back and drain.
        next_pc = 32'h100;
        drive(2'b11, 2'd0, 1'b0); step();
        drive(2'b00, 2'd0, 1'b0); step();
        check("grp_pc0", bus.out[0].pc, 32'h100);
        drive(2'b00, 2'd2, 1'b0); step();

        // Compaction of lane 1 into slot 0 of the group.
        next_pc = 32'h200;
        drive(2'b10, 2'd0, 1'b0); step();
        drive(2'b00, 2'd0, 1'b0);
        check("compact_pc", bus.out[0].pc, 32'h204);
        step();
        drive(2'b00, 2'd2, 1'b0); step();

        // Fill to 7 across the tail wrap, then hold a group while dequeuing.
        repeat (3) begin drive(2'b11, 2'd0, 1'b0); step(); end
        drive(2'b01, 2'd0, 1'b0); step();
        drive(2'b11, 2'd2, 1'b0);
        check("full7_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        bus.deq_num = 2'd0;
        check("after_deq_occ", 32'(bus.occupancy), 32'd5);
        step();
        repeat (5) begin drive(2'b00, 2'd2, 1'b0); step(); end

        // Flush with a concurrent enqueue and dequeue.
        repeat (3) begin drive(2'b11, 2'd0, 1'b0); step(); end
        drive(2'b11, 2'd2, 1'b1); step();
        drive(2'b00, 2'd0, 1'b0);
        check("flush_occ", 32'(bus.occupancy), 32'd0);
        repeat (2) step();

        // deq_num above out_count is clamped.
        drive(2'b01, 2'd0, 1'b0); step();
        drive(2'b00, 2'd2, 1'b0); step();
        drive(2'b11, 2'd0, 1'b0); step();
        drive(2'b00, 2'd0, 1'b0); step();
        drive(2'b00, 2'd2, 1'b0); step();

        // Fill to DEPTH and hold a group for three stalled cycles.
        repeat (4) begin drive(2'b11, 2'd0, 1'b0); step(); end
        begin
`ifdef ID_QUEUE_PERF_EN
            logic [31:0] s0;
            s0 = stall_cycles;
`endif
            drive(2'b11, 2'd0, 1'b0);
            repeat (3) step();
            bus.in_valid = 2'b00;
`ifdef ID_QUEUE_PERF_EN
            check("stall_delta", stall_cycles - s0, 32'd3);
`endif
            step();
        end
        repeat (4) begin drive(2'b00, 2'd2, 1'b0); step(); end

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive(N'($urandom_range(0, 3)), OW'($urandom_range(0, 2)),
                  ($urandom_range(0, 31) == 0));
            step();
        end
        drive(2'b00, 2'd0, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_queue.md
Name: id_queue

Overview:
- N-lane decode stage with a decoded-instruction buffer.
- Each fetch lane goes through a decoder instance; valid results are compacted and written into a circular queue of decode_result entries.
- Dispatch drains up to N entries per cycle from the head.
- Decouples fetch from reservation-station availability and supports pipeline flush on branch mispredict.

Parameters:
- N, 2, fetch/decode lanes and max dequeue per cycle.
- DEPTH, 8, queue entries; power of two, DEPTH >= N.
- CW, $clog2(DEPTH+1), width of occupancy and count fields (derived, localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  discard all queued entries and same-cycle enqueue.
- in_valid[N]  input  1  per-lane instruction valid.
- instr[N]  input  32  raw instruction per lane.
- pc[N]  input  32  instruction PC per lane.
- in_ready  output  1  queue can accept a full N-lane group this cycle.
- out[N]  output  decode_result  head entries; out[i] = entry head+i.
- out_count  output  $clog2(N+1)  number of valid head entries presented, min(count, N).
- deq_num  input  $clog2(N+1)  entries consumed by dispatch this cycle.
- occupancy  output  CW  current entry count.

Behaviour:
- Reset (async, rst_n=0):
  - head=0, tail=0, count=0.
  - in_ready=1, out_count=0, occupancy=0, all out[i].is_valid=0.
- Decode is combinational per lane. Decoder Op/Qj/Qk/Dest/Vj/Vk/A/Unit/rwmm/A_rdy are stored unchanged; pc is stored from the input.
- in_ready = (DEPTH - count) >= N, computed from the registered count only. Same-cycle dequeue does not raise in_ready (no comb path deq_num -> in_ready).
- Enqueue fires when in_ready & |in_valid & !flush.
  - Only valid lanes are written, in lane order.
  - Valid lane k goes to slot (tail + popcount(in_valid[0..k-1])) mod DEPTH.
  - tail advances by popcount(in_valid).
  - Holes between lanes are never written.
- Dequeue: eff_deq = min(deq_num, out_count); head advances by eff_deq. A deq_num above out_count is clamped, not an error.
- Count update: count_next = count + enq_cnt - eff_deq. Simultaneous enqueue and dequeue are legal. Indices wrap mod DEPTH.
- Outputs:
  - out[i].is_valid = (i < out_count).
  - Other out[i] fields are don't-care when invalid; the bench must not check them.
  - Outputs are registered-state driven: storage read via head; no input-to-output combinational path.
- Flush has priority over enqueue and dequeue. Next cycle: head=tail=count=0, out_count=0, in_ready=1.
- Latency: an instruction accepted in cycle t appears at out in cycle t+1 at the earliest, in program order.
- When in_ready=0, fetch must hold its group. The queue ignores in_valid and does not record a partial group.

Optional Feature:
- Macro: ID_QUEUE_PERF_EN.
- When defined, adds the following outputs. Both reset to 0, wrap at 2^32, and are not cleared by flush.
  - stall_cycles (32): increments each cycle with |in_valid & !in_ready & !flush.
  - full_cycles (32): increments each cycle with count==DEPTH.
- When undefined, these ports and counters do not exist and the behaviour is otherwise identical.

Decomposition:
- Shared package:
  - decode_result struct.
  - unit and ldst_mode enums.
  - A popcount function for N-bit vectors.
- Sub-modules:
  - The existing decoder is instantiated N times in a generate loop.
  - One natural new sub-module: id_queue_ram, holding DEPTH x decode_result storage with N write ports (index, data, enable) and N combinational read ports.
- Pointer and count logic stays in id_queue.

Test Plan (N=2, DEPTH=8):
- Reset, then 5 idle cycles -> occupancy=0, out_count=0, in_ready=1, out[0].is_valid=0.
- Enqueue pc {0x100,0x104}, both valid, with deq_num=0 -> next cycle occupancy=2, out_count=2, out[0].pc=0x100, out[1].pc=0x104.
- Compaction: in_valid={0,1} with pc[1]=0x204 on an empty queue -> next cycle out_count=1, out[0].pc=0x204.
- Fill to 7 entries -> in_ready=0. Hold a group with deq_num=2 -> in_ready stays 0 that cycle; next cycle occupancy=5, in_ready=1. No entry is lost or duplicated across the tail wrap past slot 7.
- Queue holds 6 entries; flush=1 together with an enqueue and deq_num=2 -> next cycle occupancy=0, out_count=0; the flushed group is never output.
- deq_num=2 with out_count=1 -> occupancy drops by exactly 1, head advances by 1.
  - With ID_QUEUE_PERF_EN defined, add: 3 stalled cycles increment stall_cycles by 3.
